picorv32_irq_ctrl: RTL and testbench

PICORV32_IRQ_CTRL -- requirements
Module: picorv32_irq_ctrl

---
 rtl/picorv32_irq_pkg.sv | 37 +++
 rtl/irq_sync.sv | 31 +++
 rtl/picorv32_irq_ctrl.sv | 157 +++++++++++++++
 tb/tb_picorv32_irq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_irq_pkg.sv
// Shared definitions for the picorv32 interrupt controller: Wishbone register
// offsets, CTRL bit positions, map size and a byte-enable helper.
package picorv32_irq_pkg;

    // Byte offsets within the 32-byte register window
    localparam logic [4:0] OFF_CTRL    = 5'h00;
    localparam logic [4:0] OFF_LOAD    = 5'h04;
    localparam logic [4:0] OFF_COUNT   = 5'h08;
    localparam logic [4:0] OFF_MASK    = 5'h0C;
    localparam logic [4:0] OFF_PENDING = 5'h10;
    localparam logic [4:0] OFF_FORCE   = 5'h14;
    localparam int unsigned MAP_SIZE   = 32;

    // Word indices as seen on wb_adr_i[4:2]
    localparam logic [2:0] IDX_CTRL    = OFF_CTRL[4:2];
    localparam logic [2:0] IDX_LOAD    = OFF_LOAD[4:2];
    localparam logic [2:0] IDX_COUNT   = OFF_COUNT[4:2];
    localparam logic [2:0] IDX_MASK    = OFF_MASK[4:2];
    localparam logic [2:0] IDX_PENDING = OFF_PENDING[4:2];
    localparam logic [2:0] IDX_FORCE   = OFF_FORCE[4:2];

    // CTRL register layout
    localparam int unsigned CTRL_EN_BIT = 0;
    localparam int unsigned CTRL_AR_BIT = 1;
    localparam int unsigned CTRL_W      = 2;

    // Expand 4 byte enables into a 32-bit bit mask
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-stage flip-flop synchroniser for asynchronous level inputs.
// Ports: clk_i/rst_n_i clock and async active-low reset, d_i raw inputs,
//        q_o synchronised outputs (STAGES cycles of latency).
module irq_sync #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/picorv32_irq_ctrl.sv
// Interrupt controller for picorv32: Wishbone-mapped timer, pending/mask
// registers and synchronised edge-triggered external interrupt sources.
// Ports: clk_i, rst_n_i (async active-low); wb_* classic Wishbone slave;
//        ext_irq_i async level sources; irq_o registered PENDING & MASK.
module picorv32_irq_ctrl
    import picorv32_irq_pkg::*;
#(
    parameter int unsigned TIMER_IRQ_BIT = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic [31:0] ext_irq_i,
    output logic [31:0] irq_o
);

    // Edge masking must cover the synchroniser fill time, otherwise a source
    // already high at reset release shows up as a 0->1 edge.
    localparam logic [2:0] INH_INIT = 3'(SYNC_STAGES + 1);

    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       load_q, load_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       mask_q, mask_d;
    logic [31:0]       pend_q, pend_d;
    logic [31:0]       irq_q, irq_d;
    logic [31:0]       hist_q;
    logic [2:0]        inh_q;

    logic [31:0] sync_w;
    logic [31:0] edge_w;
    logic [31:0] bmask;
    logic [31:0] wr_bits;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic [2:0]  reg_idx;
    logic        bus_req;
    logic        bus_wr;
    logic        timer_fire;
    logic        unused_adr;

    assign unused_adr = ^wb_adr_i[1:0];

    irq_sync #(
        .WIDTH  (32),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (ext_irq_i),
        .q_o     (sync_w)
    );

    always_comb begin
        reg_idx = wb_adr_i[4:2];
        bus_req = wb_cyc_i & wb_stb_i & ~ack_q;
        bus_wr  = bus_req & wb_we_i;
        bmask   = byte_mask(wb_sel_i);
        wr_bits = wb_dat_i & bmask;
        edge_w  = (inh_q == 3'd0) ? (sync_w & ~hist_q) : '0;
    end

    always_comb begin
        ack_d      = bus_req;
        dat_d      = '0;
        ctrl_d     = ctrl_q;
        load_d     = load_q;
        mask_d     = mask_q;
        count_d    = count_q;
        timer_fire = 1'b0;
        set_vec    = edge_w;
        clr_vec    = '0;

        if (bus_req && !wb_we_i) begin
            case (reg_idx)
                IDX_CTRL:    dat_d = {{(32-CTRL_W){1'b0}}, ctrl_q};
                IDX_LOAD:    dat_d = load_q;
                IDX_COUNT:   dat_d = count_q;
                IDX_MASK:    dat_d = mask_q;
                IDX_PENDING: dat_d = pend_q;
                default:     dat_d = '0;
            endcase
        end

        if (bus_wr) begin
            case (reg_idx)
                IDX_CTRL:    if (wb_sel_i[0]) ctrl_d = wb_dat_i[CTRL_W-1:0];
                IDX_LOAD:    load_d = (load_q & ~bmask) | wr_bits;
                IDX_MASK:    mask_d = (mask_q & ~bmask) | wr_bits;
                IDX_PENDING: clr_vec = wr_bits;
                IDX_FORCE:   set_vec = set_vec | wr_bits;
                default:     ;
            endcase
        end

        // A bus write to COUNT wins over decrement/reload; no expiry then.
        if (bus_wr && reg_idx == IDX_COUNT) begin
            count_d = (count_q & ~bmask) | wr_bits;
        end else if (ctrl_q[CTRL_EN_BIT] && count_q != '0) begin
            if (count_q == 32'd1) begin
                timer_fire = 1'b1;
                count_d    = ctrl_q[CTRL_AR_BIT] ? load_q : '0;
            end else begin
                count_d = count_q - 32'd1;
            end
        end

        set_vec[TIMER_IRQ_BIT] = set_vec[TIMER_IRQ_BIT] | timer_fire;

        // Set takes priority over a simultaneous W1C of the same bit.
        pend_d = (pend_q & ~clr_vec) | set_vec;
        irq_d  = pend_q & mask_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            irq_q   <= '0;
            hist_q  <= '0;
            inh_q   <= INH_INIT;
        end else begin
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
            hist_q  <= sync_w;
            if (inh_q != 3'd0) begin
                inh_q <= inh_q - 3'd1;
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_picorv32_irq_ctrl.sv
// Directed self-checking bench for picorv32_irq_ctrl.
module tb_picorv32_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [4:0]  adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;
    logic [31:0] ext;
    logic [31:0] irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    picorv32_irq_ctrl #(
        .TIMER_IRQ_BIT (4),
        .SYNC_STAGES   (2)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat_w),
        .wb_sel_i  (sel),
        .wb_dat_o  (dat_r),
        .wb_ack_o  (ack),
        .ext_irq_i (ext),
        .irq_o     (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after one idle cycle.
    task automatic wb_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = s;
        @(posedge clk);
        @(negedge clk);
        chk("wr_ack", {31'b0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_rd(input logic [4:0] a, output logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        chk("rd_ack", {31'b0, ack}, 32'd1);
        d = dat_r;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int acks;

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_w = '0; sel = '0; ext = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_dat", dat_r, 32'd0);
        chk("rst_irq", irq, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            wb_rd(5'(i * 4), d);
            chk("rst_reg", d, 32'd0);
        end

        // Register access, byte enables, RAZ/WI
        wb_wr(5'h04, 32'hA5A5_0055, 4'hF);
        wb_rd(5'h04, d);  chk("load_rw", d, 32'hA5A5_0055);
        wb_wr(5'h0C, 32'hFFFF_FFFF, 4'hF);
        wb_wr(5'h0C, 32'h1234_5678, 4'h5);
        wb_rd(5'h0C, d);  chk("mask_sel", d, 32'hFF34_FF78);
        wb_wr(5'h00, 32'hFFFF_FFFF, 4'hF);
        wb_rd(5'h00, d);  chk("ctrl_raz", d, 32'h0000_0003);
        wb_wr(5'h00, 32'h0, 4'hF);
        wb_wr(5'h18, 32'hFFFF_FFFF, 4'hF);
        wb_rd(5'h18, d);  chk("unmap18", d, 32'd0);
        wb_rd(5'h1C, d);  chk("unmap1C", d, 32'd0);

        // Held strobe: ack on alternate cycles
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 5'h04;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            acks += int'(ack);
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("held_stb_acks", 32'(acks), 32'd2);

        // FORCE with byte enables
        wb_wr(5'h14, 32'h20, 4'h1);
        wb_rd(5'h10, d);  chk("force_sel1", d, 32'h20);
        wb_rd(5'h14, d);  chk("force_raz", d, 32'd0);
        wb_wr(5'h10, 32'hFFFF_FFFF, 4'hF);
        wb_wr(5'h14, 32'h20, 4'h2);
        wb_rd(5'h10, d);  chk("force_sel2", d, 32'd0);

        // Timer with autoreload
        wb_wr(5'h04, 32'd10, 4'hF);
        wb_wr(5'h08, 32'd10, 4'hF);
        wb_wr(5'h0C, 32'h10, 4'hF);
        wb_wr(5'h00, 32'h3, 4'h1);
        repeat (9) @(negedge clk);
        chk("tmr_irq_early", irq, 32'd0);
        @(negedge clk);
        chk("tmr_irq_rise", irq, 32'h10);
        wb_wr(5'h00, 32'h0, 4'h1);
        wb_rd(5'h08, d);  chk("tmr_reload", d, 32'd8);
        wb_rd(5'h10, d);  chk("tmr_pend", d, 32'h10);
        repeat (3) @(negedge clk);
        wb_rd(5'h08, d);  chk("tmr_frozen", d, 32'd8);

        // W1C on the same edge as expiry
        wb_wr(5'h08, 32'd0, 4'hF);
        wb_wr(5'h10, 32'hFFFF_FFFF, 4'hF);
        wb_wr(5'h00, 32'h1, 4'h1);
        wb_wr(5'h08, 32'd2, 4'hF);
        wb_wr(5'h10, 32'h10, 4'h1);
        wb_rd(5'h10, d);  chk("w1c_vs_set", d, 32'h10);
        wb_rd(5'h08, d);  chk("cnt_hold0", d, 32'd0);

        // Autoreload with LOAD=0: single expiry only
        wb_wr(5'h10, 32'hFFFF_FFFF, 4'hF);
        wb_wr(5'h04, 32'd0, 4'hF);
        wb_wr(5'h00, 32'h3, 4'h1);
        wb_wr(5'h08, 32'd2, 4'hF);
        repeat (3) @(negedge clk);
        wb_rd(5'h10, d);  chk("ar0_fire", d, 32'h10);
        wb_wr(5'h10, 32'h10, 4'h1);
        repeat (5) @(negedge clk);
        wb_rd(5'h10, d);  chk("ar0_quiet", d, 32'd0);
        wb_rd(5'h08, d);  chk("ar0_cnt", d, 32'd0);
        wb_wr(5'h00, 32'h0, 4'h1);

        // External interrupt pulse
        wb_wr(5'h0C, 32'h80, 4'hF);
        ext[7] = 1'b1;
        repeat (3) @(negedge clk);
        ext[7] = 1'b0;
        repeat (6) @(negedge clk);
        chk("ext_irq", irq, 32'h80);
        wb_rd(5'h10, d);  chk("ext_pend", d, 32'h80);
        chk("ext_irq_hold", irq, 32'h80);
        wb_wr(5'h10, 32'h80, 4'h1);
        chk("ext_irq_clr", irq, 32'd0);
        wb_rd(5'h10, d);  chk("ext_pend_clr", d, 32'd0);

        // Async reset drops ack immediately
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 5'h0C;
        @(posedge clk);
        #1;
        chk("pre_rst_ack", {31'b0, ack}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_ack", {31'b0, ack}, 32'd0);
        chk("rst_drop_irq", irq, 32'd0);
        chk("rst_drop_dat", dat_r, 32'd0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during a pending write, ext[3] held high across release
        wb_wr(5'h04, 32'h55, 4'hF);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 5'h04; dat_w = 32'hDEAD; sel = 4'hF;
        ext[3] = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rstw_ack", {31'b0, ack}, 32'd0);
        chk("rstw_irq", irq, 32'd0);
        chk("rstw_dat", dat_r, 32'd0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        wb_rd(5'h04, d);  chk("rstw_load", d, 32'd0);
        repeat (6) @(negedge clk);
        wb_rd(5'h10, d);  chk("held_no_edge", d, 32'd0);
        ext[3] = 1'b0;
        repeat (4) @(negedge clk);
        ext[3] = 1'b1;
        repeat (5) @(negedge clk);
        wb_rd(5'h10, d);  chk("post_rst_edge", d, 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
